// File: rtl/led_blinker_bank_if.sv
// Configuration bus for the LED blinker bank: a one-cycle write strobe
// carrying the target channel, the new mode and its argument.
interface led_blinker_bank_if;
  logic       cfg_write;
  logic [2:0] cfg_ch;
  logic [2:0] cfg_mode;
  logic [7:0] cfg_arg;

  modport master (output cfg_write, cfg_ch, cfg_mode, cfg_arg);
  modport slave  (input  cfg_write, cfg_ch, cfg_mode, cfg_arg);
endinterface

// File: rtl/led_blinker_bank.sv
// Multi-channel LED driver sharing one free-running counter. Each channel
// runs as OFF, ON, BLINK (counter bit tap), PWM (duty compare) or PULSE
// (one-shot measured in prescaled ticks, falling back to OFF when done).
module led_blinker_bank #(
  parameter int NUM_CH        = 5,
  parameter int CNT_WIDTH     = 32,
  parameter int PWM_WIDTH     = 8,
  parameter int PRESCALE_LOG2 = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  led_blinker_bank_if.slave   cfg,
  output logic [NUM_CH-1:0]   led_out,
  output logic [NUM_CH-1:0]   pulse_active
);

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_ON    = 3'd1,
    MODE_BLINK = 3'd2,
    MODE_PWM   = 3'd3,
    MODE_PULSE = 3'd4
  } mode_t;

  localparam int         TAP_W   = $clog2(CNT_WIDTH);
  localparam logic [7:0] MAX_TAP = 8'(CNT_WIDTH - 1);

  logic [CNT_WIDTH-1:0] counter;
  logic                 tick;
  mode_t                mode_q      [NUM_CH];
  logic [7:0]           arg_q       [NUM_CH];
  logic [7:0]           pulse_cnt_q [NUM_CH];
  mode_t                new_mode;
  logic [7:0]           new_arg;

  // Shared free-running counter; freezes while enable is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter <= '0;
    end else if (enable) begin
      counter <= counter + CNT_WIDTH'(1);
    end
  end

  assign tick = enable & (&counter[PRESCALE_LOG2-1:0]);

  // Decode an incoming write: unknown modes become OFF, BLINK taps are clamped to the counter top bit.
  always_comb begin
    new_mode = MODE_OFF;
    new_arg  = cfg.cfg_arg;
    case (cfg.cfg_mode)
      3'd1: new_mode = MODE_ON;
      3'd2: begin
        new_mode = MODE_BLINK;
        if (cfg.cfg_arg > MAX_TAP) new_arg = MAX_TAP;
      end
      3'd3: new_mode = MODE_PWM;
      3'd4: new_mode = MODE_PULSE;
      default: new_mode = MODE_OFF;
    endcase
  end

  // Per-channel mode state: a write always wins over the pulse timer, which counts ticks down and then returns to OFF.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        mode_q[ch]      <= MODE_OFF;
        arg_q[ch]       <= '0;
        pulse_cnt_q[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (cfg.cfg_write && (cfg.cfg_ch == 3'(ch))) begin
          mode_q[ch]      <= new_mode;
          arg_q[ch]       <= new_arg;
          pulse_cnt_q[ch] <= cfg.cfg_arg;
        end else if ((mode_q[ch] == MODE_PULSE) && tick) begin
          if (pulse_cnt_q[ch] == 8'd0) begin
            mode_q[ch] <= MODE_OFF;
          end else begin
            pulse_cnt_q[ch] <= pulse_cnt_q[ch] - 8'd1;
          end
        end
      end
    end
  end

  // Registered LED drive, one clock behind the counter and the mode registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        case (mode_q[ch])
          MODE_ON:    led_out[ch] <= 1'b1;
          MODE_BLINK: led_out[ch] <= counter[arg_q[ch][TAP_W-1:0]];
          MODE_PWM:   led_out[ch] <= (counter[PWM_WIDTH-1:0] < arg_q[ch][PWM_WIDTH-1:0]);
          MODE_PULSE: led_out[ch] <= 1'b1;
          default:    led_out[ch] <= 1'b0;
        endcase
      end
    end
  end

  // Pulse status comes straight from the mode registers so it drops at the expiry edge.
  always_comb begin
    pulse_active = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pulse_active[ch] = (mode_q[ch] == MODE_PULSE);
    end
  end

endmodule
